// File: rtl/nucleo_cifra_simon_if.sv
// Handshake and data bundle between the Simon core, its plaintext source, key schedule and consumer.
// slave = the core's view; master = the environment driving it.
interface nucleo_cifra_simon_if #(
    parameter int W = 64
);
    logic           valid_i;
    logic           ready_o;
    logic [2*W-1:0] bloco_i;
    logic [W-1:0]   kj_i;
    logic           chave_enable_o;
    logic           valid_o;
    logic           ready_i;
    logic [2*W-1:0] bloco_o;
    logic           ocupado_o;

    modport slave (
        input  valid_i, bloco_i, kj_i, ready_i,
        output ready_o, chave_enable_o, valid_o, bloco_o, ocupado_o
    );

    modport master (
        output valid_i, bloco_i, kj_i, ready_i,
        input  ready_o, chave_enable_o, valid_o, bloco_o, ocupado_o
    );
endinterface

// File: rtl/nucleo_cifra_simon.sv
// Simon 128/128 encryption round engine, one round per clock, round keys streamed from esquema_chave.
// Latency: 69 cycles from acceptance to valid_o; one block per 70 cycles at best.
// Backpressure: ready_o low while busy; ciphertext held in PRONTO until ready_i, no input buffering.
module nucleo_cifra_simon #(
    parameter int NUM_RODADAS     = 68,
    parameter int LARGURA_PALAVRA = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    nucleo_cifra_simon_if.slave  bus
);
    localparam int         W      = LARGURA_PALAVRA;
    localparam logic [6:0] ULTIMA = 7'(NUM_RODADAS - 1);

    typedef enum logic [1:0] {
        OCIOSO  = 2'd0,
        RODANDO = 2'd1,
        PRONTO  = 2'd2
    } estado_t;

    estado_t      state_q, state_d;
    logic [W-1:0] x_q, x_d;
    logic [W-1:0] y_q, y_d;
    logic [6:0]   cnt_q, cnt_d;
    logic         ready_q, ready_d;
    logic         valid_q, valid_d;
    logic         ocupado_q, ocupado_d;

    function automatic logic [W-1:0] rol(input logic [W-1:0] v, input int n);
        return (v << n) | (v >> (W - n));
    endfunction

    function automatic logic [W-1:0] simon_f(input logic [W-1:0] v);
        return (rol(v, 1) & rol(v, 8)) ^ rol(v, 2);
    endfunction

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        cnt_d     = cnt_q;
        ready_d   = ready_q;
        valid_d   = valid_q;
        ocupado_d = ocupado_q;
        case (state_q)
            OCIOSO: begin
                if (bus.valid_i && ready_q) begin
                    x_d       = bus.bloco_i[2*W-1:W];
                    y_d       = bus.bloco_i[W-1:0];
                    cnt_d     = '0;
                    state_d   = RODANDO;
                    ready_d   = 1'b0;
                    ocupado_d = 1'b1;
                end
            end
            RODANDO: begin
                x_d = y_q ^ simon_f(x_q) ^ bus.kj_i;
                y_d = x_q;
                // counter parks on the last round index instead of wrapping
                if (cnt_q == ULTIMA) begin
                    state_d = PRONTO;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            PRONTO: begin
                if (bus.ready_i) begin
                    state_d   = OCIOSO;
                    valid_d   = 1'b0;
                    ready_d   = 1'b1;
                    ocupado_d = 1'b0;
                end
            end
            default: begin
                state_d   = OCIOSO;
                ready_d   = 1'b1;
                valid_d   = 1'b0;
                ocupado_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= OCIOSO;
            x_q       <= '0;
            y_q       <= '0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            ocupado_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            cnt_q     <= cnt_d;
            ready_q   <= ready_d;
            valid_q   <= valid_d;
            ocupado_q <= ocupado_d;
        end
    end

    // key schedule advances only while rounds are running; otherwise it reloads from the key
    assign bus.chave_enable_o = (state_q == RODANDO);
    assign bus.ready_o        = ready_q;
    assign bus.valid_o        = valid_q;
    assign bus.ocupado_o      = ocupado_q;
    assign bus.bloco_o        = (state_q == PRONTO) ? {x_q, y_q} : '0;

endmodule

// File: tb/tb_nucleo_cifra_simon.sv
// Directed bench for nucleo_cifra_simon: Simon 128/128 known answer, handshake timing,
// backpressure, busy rejection and reset abort, with a behavioural key schedule feeding kj_i.
module tb_nucleo_cifra_simon;

    localparam logic [127:0] KAT_P = 128'h63736564207372656c6c657661727420;
    localparam logic [127:0] KAT_C = 128'h49681b1e1e54fe3f65aa832af84e0bbc;
    localparam logic [127:0] P2    = 128'h0123456789abcdeffedcba9876543210;

    logic clk = 1'b0;
    logic clk_run = 1'b0;
    logic rst_n;

    int n_checks = 0;
    int n_errors = 0;

    logic [63:0] rk [0:67];
    int idx = 0;

    nucleo_cifra_simon_if #(.W(64)) bus ();

    nucleo_cifra_simon #(
        .NUM_RODADAS    (68),
        .LARGURA_PALAVRA(64)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 if (clk_run) clk = ~clk;

    // behavioural esquema_chave: reloads while enable is low, steps one key per enabled cycle
    always @(posedge clk) begin
        if (bus.chave_enable_o === 1'b1) idx <= (idx >= 67) ? 67 : idx + 1;
        else                             idx <= 0;
    end
    assign bus.kj_i = rk[idx];

    function automatic logic [63:0] rol(input logic [63:0] v, input int n);
        return (v << n) | (v >> (64 - n));
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [127:0] simon_ref(input logic [127:0] p);
        logic [63:0] x, y, t;
        x = p[127:64];
        y = p[63:0];
        for (int r = 0; r < 68; r++) begin
            t = x;
            x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ rk[r];
            y = t;
        end
        return {x, y};
    endfunction

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_ready"},  128'(bus.ready_o),        128'd1);
        check_val({tag, "_valid"},  128'(bus.valid_o),        128'd0);
        check_val({tag, "_enable"}, 128'(bus.chave_enable_o), 128'd0);
        check_val({tag, "_busy"},   128'(bus.ocupado_o),      128'd0);
        check_val({tag, "_bloco"},  bus.bloco_o,              128'd0);
    endtask

    // Ends at the first negedge after the acceptance edge
    task automatic accept(input logic [127:0] p);
        @(negedge clk);
        bus.valid_i = 1'b1;
        bus.bloco_i = p;
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    // n counts negedges after acceptance; first call is at n=1. Optionally injects a block at n==inj_at.
    task automatic wait_valid(input int inj_at, input logic [127:0] inj_blk,
                              output int n, output int en_cnt, output int en_first,
                              output int en_last, output int rdy_hi);
        n = 1; en_cnt = 0; en_first = -1; en_last = -1; rdy_hi = 0;
        while (bus.valid_o !== 1'b1 && n < 300) begin
            if (n == inj_at) begin
                bus.valid_i = 1'b1;
                bus.bloco_i = inj_blk;
            end
            if (bus.chave_enable_o === 1'b1) begin
                en_cnt++;
                if (en_first < 0) en_first = n;
                en_last = n;
                if (bus.ready_o !== 1'b0) rdy_hi++;
            end
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int n, ec, ef, el, rh;
        logic [63:0] zz;
        logic [127:0] p2_c;

        rk[0] = 64'h0706050403020100;
        rk[1] = 64'h0f0e0d0c0b0a0908;
        zz    = 64'h7369f885192c0ef5;
        for (int i = 2; i < 68; i++)
            rk[i] = 64'hfffffffffffffffc ^ {63'd0, zz[(i - 2) % 62]} ^ rk[i-2]
                    ^ ror(rk[i-1], 3) ^ ror(rk[i-1], 4);
        p2_c = simon_ref(P2);

        rst_n       = 1'b1;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.bloco_i = '0;

        // asynchronous reset with the clock stopped
        #3 rst_n = 1'b0;
        #1 check_idle_outputs("rst");
        clk_run = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // known answer, ready_i high
        bus.ready_i = 1'b1;
        accept(KAT_P);
        wait_valid(0, '0, n, ec, ef, el, rh);
        check_val("kat_latency",  128'(n),  128'd69);
        check_val("kat_en_count", 128'(ec), 128'd68);
        check_val("kat_en_first", 128'(ef), 128'd1);
        check_val("kat_en_last",  128'(el), 128'd68);
        check_val("kat_ready_hi_in_window", 128'(rh), 128'd0);
        check_val("kat_ct",       bus.bloco_o, KAT_C);
        check_val("kat_busy",     128'(bus.ocupado_o), 128'd1);
        @(negedge clk);
        check_idle_outputs("kat_drain");

        // backpressure: hold result for 10 cycles
        bus.ready_i = 1'b0;
        accept(KAT_P);
        wait_valid(0, '0, n, ec, ef, el, rh);
        check_val("bp_latency", 128'(n), 128'd69);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("bp_hold_ct",    bus.bloco_o, KAT_C);
            check_val("bp_hold_valid", 128'(bus.valid_o), 128'd1);
            check_val("bp_hold_ready", 128'(bus.ready_o), 128'd0);
        end
        bus.ready_i = 1'b1;
        @(negedge clk);
        check_val("bp_release_valid", 128'(bus.valid_o), 128'd0);
        check_val("bp_release_ready", 128'(bus.ready_o), 128'd1);

        // busy rejection: second block offered during the run and kept asserted
        accept(KAT_P);
        wait_valid(5, P2, n, ec, ef, el, rh);
        check_val("busy_latency", 128'(n), 128'd69);
        check_val("busy_ct",      bus.bloco_o, KAT_C);
        @(negedge clk);
        check_val("busy_p2_waits_ready", 128'(bus.ready_o), 128'd1);
        check_val("busy_p2_waits_valid", 128'(bus.valid_o), 128'd0);
        @(posedge clk);
        @(negedge clk);
        bus.valid_i = 1'b0;
        check_val("busy_p2_accepted_ready",  128'(bus.ready_o),        128'd0);
        check_val("busy_p2_accepted_enable", 128'(bus.chave_enable_o), 128'd1);
        wait_valid(0, '0, n, ec, ef, el, rh);
        check_val("p2_latency", 128'(n), 128'd69);
        check_val("p2_ct",      bus.bloco_o, p2_c);
        @(negedge clk);

        // reset abort around round 30
        accept(KAT_P);
        repeat (29) @(negedge clk);
        check_val("abort_running", 128'(bus.chave_enable_o), 128'd1);
        rst_n = 1'b0;
        #1 check_idle_outputs("abort");
        @(negedge clk);
        rst_n = 1'b1;
        accept(KAT_P);
        wait_valid(0, '0, n, ec, ef, el, rh);
        check_val("rerun_latency", 128'(n), 128'd69);
        check_val("rerun_ct",      bus.bloco_o, KAT_C);
        @(negedge clk);
        check_val("rerun_drain_ready", 128'(bus.ready_o), 128'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
